// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PC_W      = 32;
  // Bypass bus: valid + addr + data
  localparam int unsigned BYP_BUS_W = 1 + ADDR_W + DATA_W;

  // Pending-divider-result FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  // Bypass bus payload
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } byp_bus_t;

  // r0 is hardwired to zero, so writes to it never reach the RF
  function automatic logic is_rf_write(input logic [ADDR_W-1:0] addr);
    return addr != ADDR_W'(0);
  endfunction

endpackage

// File: rtl/rf_wb_pend_buf.sv
// Single-entry holding buffer for divider results plus its starvation counter.
module rf_wb_pend_buf
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_valid,
  input  logic [ADDR_W-1:0] div_addr,
  input  logic [DATA_W-1:0] div_data,
  input  logic [PC_W-1:0]   div_pc,
  input  logic              buf_grant,
  output logic              div_ready_c,
  output logic              buf_valid_c,
  output logic              buf_force_c,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic [PC_W-1:0]   buf_pc
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_c;

  assign buf_valid_c = (state_q != IDLE);
  assign buf_force_c = (state_q == FORCE);
  // A full buffer that is being drained this cycle can take a new result
  assign div_ready_c = ~reset & (~buf_valid_c | buf_grant);
  assign load_c      = div_valid & div_ready_c;

  // State and starvation counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: fill, drain, or count lost arbitration rounds
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_c) begin
          state_d = PEND;
          cnt_d   = '0;
        end
      end
      PEND, FORCE: begin
        if (buf_grant) begin
          cnt_d   = '0;
          state_d = load_c ? PEND : IDLE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_MAX) ? FORCE : PEND;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Buffer payload, captured on a divider handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_addr <= '0;
      buf_data <= '0;
      buf_pc   <= '0;
    end else if (load_c) begin
      buf_addr <= div_addr;
      buf_data <= div_data;
      buf_pc   <= div_pc;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single RF write port between the WB stage and buffered divider results.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic        wb_ready,
  input  logic        div_valid,
  input  logic [4:0]  div_addr,
  input  logic [31:0] div_data,
  input  logic [31:0] div_pc,
  output logic        div_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        byp_buf_valid,
  output logic [4:0]  byp_buf_addr,
  output logic [31:0] byp_buf_data,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic              buf_valid_c, buf_force_c;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [PC_W-1:0]   buf_pc;
  logic              wb_req_c, buf_grant_c, wb_grant_c, wb_nowrite_c, any_grant_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_data_c;
  logic [PC_W-1:0]   sel_pc_c;
  byp_bus_t          byp_c;

  rf_wb_pend_buf #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pend_buf (
    .clk         (clk),
    .reset       (reset),
    .div_valid   (div_valid),
    .div_addr    (div_addr),
    .div_data    (div_data),
    .div_pc      (div_pc),
    .buf_grant   (buf_grant_c),
    .div_ready_c (div_ready),
    .buf_valid_c (buf_valid_c),
    .buf_force_c (buf_force_c),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data),
    .buf_pc      (buf_pc)
  );

  // Grant: lone requester wins; on conflict the buffer wins when starved or on a WAW hazard
  always_comb begin
    wb_req_c     = wb_valid & wb_we;
    buf_grant_c  = ~reset & buf_valid_c &
                   (~wb_req_c | buf_force_c | (buf_addr == wb_addr));
    wb_grant_c   = ~reset & wb_req_c & ~buf_grant_c;
    wb_nowrite_c = ~reset & wb_valid & ~wb_we;
    any_grant_c  = buf_grant_c | wb_grant_c;
    sel_addr_c   = wb_addr;
    sel_data_c   = wb_data;
    sel_pc_c     = wb_pc;
    if (buf_grant_c) begin
      sel_addr_c = buf_addr;
      sel_data_c = buf_data;
      sel_pc_c   = buf_pc;
    end
  end

  assign wb_ready = ~(wb_req_c & buf_grant_c);

  // Registered RF write port and retirement trace
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      debug_wb_pc <= '0;
    end else begin
      rf_we       <= any_grant_c & is_rf_write(sel_addr_c);
      rf_waddr    <= any_grant_c ? sel_addr_c : '0;
      rf_wdata    <= any_grant_c ? sel_data_c : '0;
      debug_wb_pc <= any_grant_c  ? sel_pc_c :
                     wb_nowrite_c ? wb_pc    : '0;
    end
  end

  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Pending result is forwardable straight from the buffer
  assign byp_c         = '{valid: buf_valid_c, addr: buf_addr, data: buf_data};
  assign byp_buf_valid = byp_c.valid;
  assign byp_buf_addr  = byp_c.addr;
  assign byp_buf_data  = byp_c.data;

endmodule
